muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for the ALU mult (ALUOp 3'b010) and div (ALUOp 3'b011) operations.
//  Sits beside the single-cycle ALU in EX; owns an iterative shift-add multiplier /
//  restoring divider and stalls the pipeline until the result is ready.
//  Other ALUOp values never reach this block's datapath.
// PARAMETERS
//  DATA_W   16                   operand/result width, bits
//  CNT_W    $clog2(DATA_W)+1     iteration counter width (derived; do not override)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        reset, synchronous, active-high
//  start        in   1        EX holds a mult/div instruction this cycle
//  alu_op       in   3        ALUOp from control unit; 010=mult, 011=div
//  op_a         in   DATA_W   multiplicand / dividend
//  op_b         in   DATA_W   multiplier / divisor
//  stall        out  1        freeze IF/ID/EX (combinational)
//  done         out  1        one-cycle pulse: result valid
//  result       out  DATA_W   low DATA_W product bits, or quotient
//  div_by_zero  out  1        sticky with result; set when div and op_b==0
// BEHAVIOUR
//  Reset: state=IDLE; stall=0, done=0, result=0, div_by_zero=0; counter, acc, operand regs=0.
//  Reset mid-operation aborts: IDLE next cycle, no done pulse, partial result discarded.
//  FSM states: IDLE, MUL, DIV, DONE.
//  IDLE: start && alu_op==010 -> MUL; start && alu_op==011 -> DIV.
//    Capture op_a/op_b and load counter=DATA_W.
//    start with any other alu_op is ignored (stay IDLE, stall=0).
//  MUL: per cycle, if mplr[0] then acc+=mcnd; mcnd<<=1; mplr>>=1; cnt--.
//    acc is DATA_W wide; overflow bits dropped. Go to DONE when cnt reaches 1->0.
//  DIV: unsigned restoring; rem={rem,quo[MSB]}; quo<<=1; if rem>=divisor then rem-=divisor, quo[0]=1.
//    Go to DONE after DATA_W iterations. rem is DATA_W+1 bits.
//  DONE: done=1 for exactly this cycle; result and div_by_zero registered; -> IDLE.
//  stall = (IDLE && start && alu_op in {010,011}) || MUL || DIV.
//    stall is 0 in DONE, so the pipeline advances on the done cycle.
//  Latency: start cycle + DATA_W iteration cycles, then done; DATA_W+1 stall cycles total.
//  result and div_by_zero hold their values until the next accepted start.
//  start asserted while busy (MUL/DIV/DONE) is ignored; the pipeline is stalled, so it cannot legally change.
//  Divide by zero: quotient = all ones (falls out of restoring algorithm), div_by_zero=1.
//  mult never sets div_by_zero.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: in IDLE, accepted start with op_b==0 goes directly to DONE.
//    result=0 for mult, all ones for div (div_by_zero=1); stall for 1 cycle only.
//  Undefined: op_b==0 runs the full DATA_W iterations, same result and flag values.
// STRUCTURE
//  Shared package cpu_pkg: ALUOP_MUL=3'b010, ALUOP_DIV=3'b011 localparams;
//    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} muldiv_state_t.
//  One sub-module: muldiv_step, a combinational single-iteration datapath.
//    Inputs: mode, acc/rem, operands. Outputs: next values.
//  This block keeps the FSM, counter and registers.
// TESTING (DATA_W=16)
//  mult 7*6: start 1 cycle -> stall 17 cycles high, done pulse, result=42, div_by_zero=0.
//  mult 0x0100*0x0100 -> result=0x0000 (overflow truncated), done after 16 iterations.
//  div 100/7 -> result=14. div 0xFFFF/1 -> result=0xFFFF.
//  div 5/0 -> result=0xFFFF, div_by_zero=1.
//    With MULDIV_EARLY_OUT_EN: done in the cycle after start, stall 1 cycle.
//  start with alu_op=000 -> no stall, no done, result unchanged.
//    Assert start again while in MUL -> ignored, one done only.
//  rst asserted at iteration 8 of a div -> next cycle IDLE, stall=0, done never pulses, result=0.
//    A new mult 3*3 afterwards -> result=9.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALUOp encodings for the multi-cycle ops and the
// mult/div sequencer state type.
package cpu_pkg;

  localparam logic [2:0] ALUOP_MUL = 3'b010;
  localparam logic [2:0] ALUOP_DIV = 3'b011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier (mode=0) or the
// unsigned restoring divider (mode=1); the sequencer registers the outputs.
module muldiv_step #(
  parameter int DATA_W = 16
) (
  input  logic              mode,
  input  logic [DATA_W:0]   acc_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W:0]   acc_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   divisor_ext;
  logic [DATA_W-1:0] addend;

  // Divide: a holds the quotient, b the divisor, acc the remainder.
  // Multiply: a holds the multiplicand, b the multiplier, acc the product.
  assign rem_sh      = {acc_in[DATA_W-1:0], a_in[DATA_W-1]};
  assign divisor_ext = {1'b0, b_in};
  assign addend      = b_in[0] ? a_in : '0;

  always_comb begin
    acc_out = acc_in;
    a_out   = a_in;
    b_out   = b_in;
    if (mode) begin
      if (rem_sh >= divisor_ext) begin
        acc_out = rem_sh - divisor_ext;
        a_out   = {a_in[DATA_W-2:0], 1'b1};
      end else begin
        acc_out = rem_sh;
        a_out   = {a_in[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_out = {1'b0, acc_in[DATA_W-1:0] + addend};
      a_out   = a_in << 1;
      b_out   = b_in >> 1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer beside the EX-stage ALU; stalls the pipeline
// until the result is ready. Define MULDIV_EARLY_OUT_EN to finish op_b==0 at once.
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_by_zero,
  output muldiv_state_t     dbg_state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  muldiv_state_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W:0]   acc_nxt;
  logic [DATA_W-1:0] a_nxt, b_nxt;
  logic              is_div;
  logic              early_out;
  logic              load, finish;

  assign is_div    = (state == MD_DIV);
  assign dbg_state = state;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (op_b == '0);
`else
  assign early_out = 1'b0;
`endif

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .mode    (is_div),
    .acc_in  (acc),
    .a_in    (a_reg),
    .b_in    (b_reg),
    .acc_out (acc_nxt),
    .a_out   (a_nxt),
    .b_out   (b_nxt)
  );

  // Handshake: start is sampled only in IDLE; stall is held high from the
  // accepting cycle through the last iteration and drops on the done cycle.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && is_muldiv_op(alu_op)) begin
          stall = 1'b1;
          load  = 1'b1;
          if (early_out)
            state_nxt = MD_DONE;
          else if (alu_op == ALUOP_DIV)
            state_nxt = MD_DIV;
          else
            state_nxt = MD_MUL;
        end
      end
      MD_MUL, MD_DIV: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = MD_DONE;
        end
      end
      MD_DONE: begin
        done      = 1'b1;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      acc         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt   <= CNT_W'(DATA_W);
        acc   <= '0;
        a_reg <= op_a;
        b_reg <= op_b;
        if (early_out) begin
          result      <= (alu_op == ALUOP_DIV) ? '1 : '0;
          div_by_zero <= (alu_op == ALUOP_DIV);
        end
      end else if (state == MD_MUL || state == MD_DIV) begin
        cnt   <= cnt - CNT_W'(1);
        acc   <= acc_nxt;
        a_reg <= a_nxt;
        b_reg <= b_nxt;
        if (finish) begin
          result      <= is_div ? a_nxt : acc_nxt[DATA_W-1:0];
          div_by_zero <= is_div && (b_reg == '0);
        end
      end
    end
  end

endmodule
